coherency_arbiter_n: RTL and testbench

Parametrised N-core bus arbiter and snooping coherency controller between the per-core L1 cache controllers and the single RAM port. Arbitrates instruction fetches, data writebacks and coherent data reads with class priority plus round-robin fairness among cores. Broadcasts snoops and invalidates to every non-requesting core and moves WORDS-word blocks either cache-to-cache (with simultaneous RAM update) or memory-to-cache, tracked by an internal beat counter.

---
 rtl/coherency_arbiter_n.sv | 261 ++++++++++++++++++++++++++
 tb/tb_coherency_arbiter_n.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherency_arbiter_n.sv
// coherency_arbiter_n: N-core bus arbiter and snooping coherency controller in front of one RAM port.
// Optional feature: define COH_SNOOP_TIMEOUT_EN to bound the SNOOP phase with a SNOOP_TO-cycle timer.
module coherency_arbiter_n #(
    parameter int NCPU     = 2,
    parameter int WORDS    = 2,
    parameter int SNOOP_TO = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCPU-1:0]        iREN,
    input  logic [NCPU-1:0]        dREN,
    input  logic [NCPU-1:0]        dWEN,
    input  logic [NCPU-1:0]        cctrans,
    input  logic [NCPU-1:0]        ccwrite,
    input  logic [32*NCPU-1:0]     iaddr,
    input  logic [32*NCPU-1:0]     daddr,
    input  logic [32*NCPU-1:0]     dstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [NCPU-1:0]        iwait,
    output logic [NCPU-1:0]        dwait,
    output logic [32*NCPU-1:0]     iload,
    output logic [32*NCPU-1:0]     dload,
    output logic [NCPU-1:0]        ccwait,
    output logic [NCPU-1:0]        ccinv,
    output logic [32*NCPU-1:0]     ccsnoopaddr,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    output logic                   ramREN,
    output logic                   ramWEN
);

    localparam int IDX_W  = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int BEAT_W = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    if (NCPU < 2 || NCPU > 8 || WORDS < 1 || SNOOP_TO < 1) begin : g_param_check
        $error("coherency_arbiter_n: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        IST,
        WST,
        SNOOP,
        C2C,
        M2C
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  req, req_n;
    logic [IDX_W-1:0]  rsp, rsp_n;
    logic [IDX_W-1:0]  rr, rr_n;
    logic [IDX_W-1:0]  rr_after;
    logic [BEAT_W-1:0] beat, beat_n;

`ifdef COH_SNOOP_TIMEOUT_EN
    localparam int TIMER_W = $clog2(SNOOP_TO + 1);
    logic [TIMER_W-1:0] timer, timer_n;
    logic               timed_out;
    assign timed_out = (int'(timer) >= SNOOP_TO - 1);
`endif

    logic              access;
    logic              last_beat;
    logic [NCPU-1:0]   req_mask;
    logic [NCPU-1:0]   dirty_vec;
    logic              others_done;
    logic [IDX_W:0]    rd_pick, wr_pick, if_pick, dirty_pick;
    logic [31:0]       req_iaddr, req_daddr, req_dstore, rsp_dstore;

    // First set bit of v found by scanning ptr, ptr+1, ... mod NCPU; MSB flags a hit.
    function automatic logic [IDX_W:0] pick_rr(input logic [NCPU-1:0] v, input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] r;
        int             p;
        r = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            p = (int'(ptr) + i) % NCPU;
            if (v[p]) r = {1'b1, IDX_W'(p)};
        end
        return r;
    endfunction

    function automatic logic [IDX_W:0] pick_lowest(input logic [NCPU-1:0] v);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NCPU - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    assign access      = (ramstate == RAM_ACCESS);
    assign last_beat   = (int'(beat) + 1 >= WORDS);
    assign req_mask    = {{(NCPU-1){1'b0}}, 1'b1} << req;
    assign dirty_vec   = ccwrite & dWEN & ~req_mask;
    assign others_done = &(ccwrite | req_mask);
    assign rd_pick     = pick_rr(cctrans & dREN, rr);
    assign wr_pick     = pick_rr(dWEN, rr);
    assign if_pick     = pick_rr(iREN, rr);
    assign dirty_pick  = pick_lowest(dirty_vec);
    assign rr_after    = (int'(req) == NCPU - 1) ? '0 : req + 1'b1;
    assign req_iaddr   = iaddr[{req, 5'b0} +: 32];
    assign req_daddr   = daddr[{req, 5'b0} +: 32];
    assign req_dstore  = dstore[{req, 5'b0} +: 32];
    assign rsp_dstore  = dstore[{rsp, 5'b0} +: 32];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            req   <= '0;
            rsp   <= '0;
            rr    <= '0;
            beat  <= '0;
`ifdef COH_SNOOP_TIMEOUT_EN
            timer <= '0;
`endif
        end else begin
            state <= state_n;
            req   <= req_n;
            rsp   <= rsp_n;
            rr    <= rr_n;
            beat  <= beat_n;
`ifdef COH_SNOOP_TIMEOUT_EN
            timer <= timer_n;
`endif
        end
    end

    // Any wait stays high unless the granted transfer completes a word this cycle.
    always_comb begin
        state_n     = state;
        req_n       = req;
        rsp_n       = rsp;
        rr_n        = rr;
        beat_n      = beat;
`ifdef COH_SNOOP_TIMEOUT_EN
        timer_n     = timer;
`endif
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramaddr     = '0;
        ramstore    = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;

        case (state)
            IDLE: begin
                beat_n = '0;
                if (rd_pick[IDX_W]) begin
                    state_n = SNOOP;
                    req_n   = rd_pick[IDX_W-1:0];
`ifdef COH_SNOOP_TIMEOUT_EN
                    timer_n = '0;
`endif
                end else if (wr_pick[IDX_W]) begin
                    state_n = WST;
                    req_n   = wr_pick[IDX_W-1:0];
                end else if (if_pick[IDX_W]) begin
                    state_n = IST;
                    req_n   = if_pick[IDX_W-1:0];
                end
            end

            IST: begin
                ramREN                    = 1'b1;
                ramaddr                   = req_iaddr;
                iload[{req, 5'b0} +: 32]  = ramload;
                if (access) begin
                    iwait[req] = 1'b0;
                    state_n    = IDLE;
                    rr_n       = rr_after;
                end
            end

            WST: begin
                ramWEN   = dWEN[req];
                ramaddr  = req_daddr;
                ramstore = req_dstore;
                if (access) dwait[req] = 1'b0;
                if (!dWEN[req]) begin
                    state_n = IDLE;
                    rr_n    = rr_after;
                end
            end

            SNOOP: begin
                ccwait = ~req_mask;
                ccinv  = ccwrite[req] ? ~req_mask : '0;
                for (int k = 0; k < NCPU; k++) begin
                    if (!req_mask[k]) ccsnoopaddr[32*k +: 32] = req_daddr;
                end
                if (dirty_pick[IDX_W]) begin
                    rsp_n   = dirty_pick[IDX_W-1:0];
                    state_n = C2C;
                end else if (others_done) begin
                    state_n = M2C;
                end
`ifdef COH_SNOOP_TIMEOUT_EN
                else if (timed_out) begin
                    state_n = M2C;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
            end

            C2C: begin
                ccwait = ~req_mask;
                ccinv  = ccwrite[req] ? ~req_mask : '0;
                for (int k = 0; k < NCPU; k++) begin
                    if (!req_mask[k]) ccsnoopaddr[32*k +: 32] = req_daddr;
                end
                dload[{req, 5'b0} +: 32] = rsp_dstore;
                ramWEN                   = 1'b1;
                ramaddr                  = req_daddr;
                ramstore                 = rsp_dstore;
                if (access) begin
                    dwait[req] = 1'b0;
                    dwait[rsp] = 1'b0;
                    beat_n     = beat + 1'b1;
                    if (last_beat) begin
                        state_n = IDLE;
                        rr_n    = rr_after;
                    end
                end
                if (!dREN[req]) begin
                    state_n = IDLE;
                    rr_n    = rr_after;
                end
            end

            M2C: begin
                ccwait                   = ~req_mask;
                ramREN                   = 1'b1;
                ramaddr                  = req_daddr;
                dload[{req, 5'b0} +: 32] = ramload;
                if (access) begin
                    dwait[req] = 1'b0;
                    beat_n     = beat + 1'b1;
                    if (last_beat) begin
                        state_n = IDLE;
                        rr_n    = rr_after;
                    end
                end
                if (!dREN[req]) begin
                    state_n = IDLE;
                    rr_n    = rr_after;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_coherency_arbiter_n.sv
// tb_coherency_arbiter_n: randomized scenario bench for coherency_arbiter_n (NCPU=4, WORDS=2, SNOOP_TO=16).
// Expectations come from a transaction-level model of grant priority, round-robin and snoop resolution.
module tb_coherency_arbiter_n;

    localparam int NCPU = 4;
    localparam int WORDS = 2;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [3:0]   iREN = '0, dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
    logic [127:0] iaddr = '0, daddr = '0, dstore = '0;
    logic [31:0]  ramload = '0;
    logic [1:0]   ramstate = FREE;
    logic [3:0]   iwait, dwait, ccwait, ccinv;
    logic [127:0] iload, dload, ccsnoopaddr;
    logic [31:0]  ramaddr, ramstore;
    logic         ramREN, ramWEN;

    int total = 0;
    int bad = 0;
    int model_rr = 0;

    coherency_arbiter_n #(.NCPU(NCPU), .WORDS(WORDS), .SNOOP_TO(16)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ramload(ramload), .ramstate(ramstate),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] w32(input logic [127:0] v, input int k);
        return v[32*k +: 32];
    endfunction

    // Round-robin rule: first requester scanning from ptr upward, wrapping.
    function automatic int first_from(input logic [3:0] v, input int ptr);
        for (int off = 0; off < NCPU; off++) begin
            if (v[(ptr + off) % NCPU]) return (ptr + off) % NCPU;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        iREN = 4'b1111;
        #2;
        total++; if (iwait !== 4'hF) begin bad++; $display("[TB] FAIL reset_iwait got=%h exp=%h", iwait, 4'hF); end
        total++; if (dwait !== 4'hF) begin bad++; $display("[TB] FAIL reset_dwait got=%h exp=%h", dwait, 4'hF); end
        total++; if ({ramREN, ramWEN} !== 2'b00) begin bad++; $display("[TB] FAIL reset_ram_en got=%b exp=00", {ramREN, ramWEN}); end
        total++; if ({ccwait, ccinv} !== 8'h00) begin bad++; $display("[TB] FAIL reset_cc got=%h exp=00", {ccwait, ccinv}); end
        total++; if ({iload, dload, ccsnoopaddr} !== '0) begin bad++; $display("[TB] FAIL reset_data got=nonzero exp=0"); end
        total++; if ({ramaddr, ramstore} !== 64'h0) begin bad++; $display("[TB] FAIL reset_ramaddr got=%h exp=0", {ramaddr, ramstore}); end
        tick();
        total++; if (ramREN !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold_ramREN got=%b exp=0", ramREN); end
        iREN = '0;
        @(negedge CLK);
        RST = 1'b0;
        model_rr = 0;
        tick();
    endtask

    task automatic test_fetch_rr();
        logic [31:0] data;
        iREN = 4'b1010;
        #1;
        total++; if (iwait !== 4'hF || ramREN !== 1'b0) begin bad++; $display("[TB] FAIL fetch_idle got=%h/%b exp=f/0", iwait, ramREN); end
        tick();
        ramstate = BUSY;
        #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== w32(iaddr, 1)) begin bad++; $display("[TB] FAIL fetch_grant1 got=%b/%h exp=1/%h", ramREN, ramaddr, w32(iaddr, 1)); end
        total++; if (iwait !== 4'hF) begin bad++; $display("[TB] FAIL fetch_busy_wait got=%h exp=f", iwait); end
        tick();
        data = $urandom();
        ramload = data;
        ramstate = ACCESS;
        #1;
        total++; if (iwait !== 4'b1101) begin bad++; $display("[TB] FAIL fetch_access_wait got=%h exp=d", iwait); end
        total++; if (w32(iload, 1) !== data) begin bad++; $display("[TB] FAIL fetch_iload got=%h exp=%h", w32(iload, 1), data); end
        tick();
        model_rr = 2;
        iREN = 4'b1000;
        ramstate = FREE;
        #1;
        total++; if (ramREN !== 1'b0 || iwait !== 4'hF) begin bad++; $display("[TB] FAIL fetch_back_idle got=%b/%h exp=0/f", ramREN, iwait); end
        tick();
        ramstate = ACCESS;
        #1;
        total++; if (ramaddr !== w32(iaddr, 3) || iwait !== 4'b0111) begin bad++; $display("[TB] FAIL fetch_grant3 got=%h/%h exp=%h/7", ramaddr, iwait, w32(iaddr, 3)); end
        tick();
        model_rr = 0;
        iREN = '0;
        ramstate = FREE;
        tick();
    endtask

    task automatic test_snoop_c2c();
        dstore[0 +: 32] = $urandom();
        dWEN = 4'b0001;
        cctrans = 4'b0100;
        dREN = 4'b0100;
        tick();
        #1;
        total++; if (ccwait !== 4'b1011) begin bad++; $display("[TB] FAIL snoop_ccwait got=%b exp=1011", ccwait); end
        for (int k = 0; k < NCPU; k++) begin
            total++;
            if (w32(ccsnoopaddr, k) !== ((k == 2) ? 32'h0 : w32(daddr, 2))) begin
                bad++; $display("[TB] FAIL snoop_addr%0d got=%h exp=%h", k, w32(ccsnoopaddr, k), (k == 2) ? 32'h0 : w32(daddr, 2));
            end
        end
        total++; if (ccinv !== 4'b0000 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin bad++; $display("[TB] FAIL snoop_quiet got=%b/%b%b exp=0000/00", ccinv, ramREN, ramWEN); end
        ccwrite = 4'b0010;
        dWEN = 4'b0011;
        dstore[32 +: 32] = 32'hDEADBEEF;
        tick();
        ramstate = BUSY;
        #1;
        total++; if (w32(dload, 2) !== 32'hDEADBEEF || ramWEN !== 1'b1 || ramstore !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL c2c_beat0 got=%h/%b/%h exp=deadbeef/1/deadbeef", w32(dload, 2), ramWEN, ramstore); end
        total++; if (ramaddr !== w32(daddr, 2) || dwait !== 4'hF) begin bad++; $display("[TB] FAIL c2c_busy got=%h/%h exp=%h/f", ramaddr, dwait, w32(daddr, 2)); end
        ramstate = ACCESS;
        #1;
        total++; if (dwait !== 4'b1001) begin bad++; $display("[TB] FAIL c2c_access0 got=%b exp=1001", dwait); end
        tick();
        dstore[32 +: 32] = 32'h0BADF00D;
        #1;
        total++; if (w32(dload, 2) !== 32'h0BADF00D || ramstore !== 32'h0BADF00D || dwait !== 4'b1001) begin
            bad++; $display("[TB] FAIL c2c_beat1 got=%h/%h/%b exp=0badf00d/0badf00d/1001", w32(dload, 2), ramstore, dwait); end
        tick();
        ccwrite = '0;
        dWEN = 4'b0001;
        cctrans = '0;
        dREN = '0;
        ramstate = FREE;
        #1;
        total++; if (ramWEN !== 1'b0 || dwait !== 4'hF || ccwait !== 4'h0) begin bad++; $display("[TB] FAIL c2c_done got=%b/%h/%h exp=0/f/0", ramWEN, dwait, ccwait); end
        model_rr = 3;
        tick();
        ramstate = ACCESS;
        #1;
        total++; if (ramWEN !== 1'b1 || ramaddr !== w32(daddr, 0) || ramstore !== w32(dstore, 0) || dwait !== 4'b1110) begin
            bad++; $display("[TB] FAIL wst got=%b/%h/%h/%b exp=1/%h/%h/1110", ramWEN, ramaddr, ramstore, dwait, w32(daddr, 0), w32(dstore, 0)); end
        tick();
        dWEN = '0;
        ramstate = FREE;
        #1;
        total++; if (ramWEN !== 1'b0) begin bad++; $display("[TB] FAIL wst_drop got=%b exp=0", ramWEN); end
        tick();
        model_rr = 1;
    endtask

    task automatic test_m2c_random();
        int r, busy;
        logic ccw_req;
        logic [3:0] mask, exp_inv;
        logic [31:0] data;
        for (int it = 0; it < 6; it++) begin
            r = $urandom_range(0, NCPU - 1);
            mask = 4'b0001 << r;
            ccw_req = 1'($urandom_range(0, 1));
            cctrans = mask;
            dREN = mask;
            tick();
            ccwrite = ~mask | (ccw_req ? mask : 4'b0000);
            exp_inv = ccw_req ? ~mask : 4'b0000;
            #1;
            total++; if (ccinv !== exp_inv || ccwait !== ~mask) begin bad++; $display("[TB] FAIL m2c_snoop%0d got=%b/%b exp=%b/%b", it, ccinv, ccwait, exp_inv, ~mask); end
            tick();
            for (int b = 0; b < WORDS; b++) begin
                busy = $urandom_range(0, 2);
                for (int c = 0; c < busy; c++) begin
                    ramstate = BUSY;
                    #1;
                    total++; if (ramREN !== 1'b1 || ramaddr !== w32(daddr, r) || dwait !== 4'hF || ccwait !== ~mask) begin
                        bad++; $display("[TB] FAIL m2c_busy%0d got=%b/%h/%h exp=1/%h/f", it, ramREN, ramaddr, dwait, w32(daddr, r)); end
                    tick();
                end
                data = $urandom();
                ramload = data;
                ramstate = ACCESS;
                #1;
                total++; if (w32(dload, r) !== data || dwait !== ~mask || ramWEN !== 1'b0) begin
                    bad++; $display("[TB] FAIL m2c_beat%0d_%0d got=%h/%b exp=%h/%b", it, b, w32(dload, r), dwait, data, ~mask); end
                tick();
            end
            cctrans = '0;
            dREN = '0;
            ccwrite = '0;
            ramstate = FREE;
            #1;
            total++; if (ramREN !== 1'b0 || ccwait !== 4'h0) begin bad++; $display("[TB] FAIL m2c_end%0d got=%b/%h exp=0/0", it, ramREN, ccwait); end
            model_rr = (r + 1) % NCPU;
            tick();
        end
    endtask

    task automatic test_arbitration_random();
        logic [3:0] rdv, wrv, ifv, mask;
        int cls, g, d;
        for (int round = 0; round < 5; round++) begin
            rdv = 4'($urandom_range(0, 15));
            wrv = 4'($urandom_range(0, 15));
            ifv = 4'($urandom_range(0, 15));
            if ((rdv | wrv | ifv) == 4'h0) ifv = 4'b0001;
            for (int step = 0; step < 16 && (rdv | wrv | ifv) != 4'h0; step++) begin
                cls = (rdv != 0) ? 1 : (wrv != 0) ? 2 : 3;
                g = first_from((cls == 1) ? rdv : (cls == 2) ? wrv : ifv, model_rr);
                mask = 4'b0001 << g;
                cctrans = rdv; dREN = rdv; dWEN = wrv; iREN = ifv;
                ccwrite = '0; ramstate = FREE;
                #1;
                total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'h0) begin bad++; $display("[TB] FAIL arb_idle got=%b%b/%h exp=00/0", ramREN, ramWEN, ccwait); end
                tick();
                if (cls == 1) begin
                    total++; if (ccwait !== ~mask) begin bad++; $display("[TB] FAIL arb_rd_grant got=%b exp=%b", ccwait, ~mask); end
                    d = -1;
                    for (int k = NCPU - 1; k >= 0; k--) if (k != g && wrv[k]) d = k;
                    ccwrite = ~mask;
                    tick();
                    if (d >= 0) begin
                        total++; if (ramWEN !== 1'b1 || ramstore !== w32(dstore, d)) begin bad++; $display("[TB] FAIL arb_c2c_rsp got=%b/%h exp=1/%h", ramWEN, ramstore, w32(dstore, d)); end
                    end else begin
                        total++; if (ramREN !== 1'b1 || ramaddr !== w32(daddr, g)) begin bad++; $display("[TB] FAIL arb_m2c got=%b/%h exp=1/%h", ramREN, ramaddr, w32(daddr, g)); end
                    end
                    rdv[g] = 1'b0;
                    cctrans = rdv; dREN = rdv;
                    tick();
                    ccwrite = '0;
                end else if (cls == 2) begin
                    total++; if (ramWEN !== 1'b1 || ramaddr !== w32(daddr, g)) begin bad++; $display("[TB] FAIL arb_wr_grant got=%b/%h exp=1/%h", ramWEN, ramaddr, w32(daddr, g)); end
                    wrv[g] = 1'b0;
                    dWEN = wrv;
                    tick();
                end else begin
                    ramstate = ACCESS;
                    #1;
                    total++; if (ramREN !== 1'b1 || ramaddr !== w32(iaddr, g) || iwait !== ~mask) begin
                        bad++; $display("[TB] FAIL arb_if_grant got=%b/%h/%b exp=1/%h/%b", ramREN, ramaddr, iwait, w32(iaddr, g), ~mask); end
                    tick();
                    ifv[g] = 1'b0;
                    iREN = ifv;
                end
                model_rr = (g + 1) % NCPU;
            end
            cctrans = '0; dREN = '0; dWEN = '0; iREN = '0; ccwrite = '0; ramstate = FREE;
            tick();
        end
    endtask

    task automatic test_reset_mid_c2c();
        cctrans = 4'b0001;
        dREN = 4'b0001;
        tick();
        ccwrite = 4'b0010;
        dWEN = 4'b0010;
        tick();
        ramstate = ACCESS;
        tick();
        #1;
        total++; if (ramWEN !== 1'b1 || dwait !== 4'b1100) begin bad++; $display("[TB] FAIL mid_c2c_beat1 got=%b/%b exp=1/1100", ramWEN, dwait); end
        RST = 1'b1;
        #1;
        total++; if (ramWEN !== 1'b0 || dwait !== 4'hF || ccwait !== 4'h0) begin bad++; $display("[TB] FAIL mid_reset got=%b/%h/%h exp=0/f/0", ramWEN, dwait, ccwait); end
        cctrans = '0; dREN = '0; ccwrite = '0; dWEN = '0; ramstate = FREE;
        tick();
        @(negedge CLK);
        RST = 1'b0;
        model_rr = 0;
        iREN = 4'b1001;
        #1;
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 4'hF) begin bad++; $display("[TB] FAIL mid_release_idle got=%b%b/%h exp=00/f", ramREN, ramWEN, dwait); end
        tick();
        total++; if (ramaddr !== w32(iaddr, first_from(4'b1001, model_rr))) begin bad++; $display("[TB] FAIL mid_rr_cleared got=%h exp=%h", ramaddr, w32(iaddr, 0)); end
        ramstate = ACCESS;
        tick();
        iREN = '0;
        ramstate = FREE;
        model_rr = 1;
        tick();
    endtask

    task automatic test_snoop_wait();
        cctrans = 4'b0001;
        dREN = 4'b0001;
        tick();
        ccwrite = 4'b0110;
        dWEN = '0;
`ifdef COH_SNOOP_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            #1;
            total++; if (ramREN !== 1'b0 || ccwait !== 4'b1110) begin bad++; $display("[TB] FAIL snoop_to_cycle%0d got=%b/%b exp=0/1110", c, ramREN, ccwait); end
            tick();
        end
        total++; if (ramREN !== 1'b1 || ramaddr !== w32(daddr, 0)) begin bad++; $display("[TB] FAIL snoop_to_m2c got=%b/%h exp=1/%h", ramREN, ramaddr, w32(daddr, 0)); end
`else
        for (int c = 1; c <= 100; c++) begin
            #1;
            total++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'b1110) begin
                bad++; $display("[TB] FAIL snoop_hold_cycle%0d got=%b%b/%b exp=00/1110", c, ramREN, ramWEN, ccwait); end
            tick();
        end
`endif
        RST = 1'b1;
        cctrans = '0; dREN = '0; ccwrite = '0;
        tick();
        @(negedge CLK);
        RST = 1'b0;
        model_rr = 0;
        tick();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired before completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < NCPU; k++) begin
            iaddr[32*k +: 32] = ($urandom() & 32'hFFFF_FFF0) | 32'(k);
            daddr[32*k +: 32] = ($urandom() & 32'hFFFF_FFF0) | 32'(k + 8);
            dstore[32*k +: 32] = $urandom();
        end
        test_reset();
        test_fetch_rr();
        test_snoop_c2c();
        test_m2c_random();
        test_arbitration_random();
        test_reset_mid_c2c();
        test_snoop_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
